// File: rtl/branch_redirect_ctrl_if.sv
// Branch redirect control bus.
//   Carries the EX-stage resolution inputs and the redirect/flush outputs
//   between the pipeline (master) and branch_redirect_ctrl (slave).
//   master : drives ex_valid, ex_jump, ex_pred_taken, ex_pc, ex_target, stall_in
//            receives pc_sel, redirect_pc, flush_if, flush_id, busy
//   slave  : the reverse directions.
//   BRANCH_REDIRECT_PERF_CNT_EN adds branch_cnt / mispred_cnt (slave outputs).
interface branch_redirect_ctrl_if #(
  parameter int unsigned XLEN = 32
);
  logic            ex_valid;
  logic            ex_jump;
  logic            ex_pred_taken;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] ex_target;
  logic            stall_in;
  logic            pc_sel;
  logic [XLEN-1:0] redirect_pc;
  logic            flush_if;
  logic            flush_id;
  logic            busy;
`ifdef BRANCH_REDIRECT_PERF_CNT_EN
  logic [31:0]     branch_cnt;
  logic [31:0]     mispred_cnt;
`endif

  modport master (
    output ex_valid, ex_jump, ex_pred_taken, ex_pc, ex_target, stall_in,
`ifdef BRANCH_REDIRECT_PERF_CNT_EN
    input  branch_cnt, mispred_cnt,
`endif
    input  pc_sel, redirect_pc, flush_if, flush_id, busy
  );

  modport slave (
    input  ex_valid, ex_jump, ex_pred_taken, ex_pc, ex_target, stall_in,
`ifdef BRANCH_REDIRECT_PERF_CNT_EN
    output branch_cnt, mispred_cnt,
`endif
    output pc_sel, redirect_pc, flush_if, flush_id, busy
  );
endinterface

// File: rtl/branch_redirect_ctrl.sv
// Branch mispredict redirect controller.
//   Detects a mispredicted control transfer in EX, registers the corrective
//   fetch address and sequences the front-end squash:
//     REDIRECT (1 cycle) : pc_sel, flush_if, flush_id
//     DRAIN (FLUSH_CYCLES-1 cycles) : flush_if only
//   Ports:
//     clk  : clock, all state on rising edge
//     rst  : synchronous active-high reset
//     bus  : branch_redirect_ctrl_if.slave (EX inputs, stall_in, redirect
//            and flush outputs, busy)
//   Parameters: FLUSH_CYCLES (1..7), XLEN (must match the bus interface).
//   Optional: define BRANCH_REDIRECT_PERF_CNT_EN for saturating branch and
//   mispredict counters on the bus.
module branch_redirect_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned XLEN         = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  branch_redirect_ctrl_if.slave  bus
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_REDIRECT = 2'd1;
  localparam logic [1:0] ST_DRAIN    = 2'd2;

  localparam logic [2:0] DRAIN_LOAD  = 3'(FLUSH_CYCLES - 1);

  logic [1:0]      r_state;
  logic [2:0]      r_cnt;
  logic [XLEN-1:0] r_redirect_pc;

  logic            w_sample;
  logic            w_event;
  logic [XLEN-1:0] w_fix_pc;

  // Only IDLE, unstalled cycles look at EX; anything else is wrong-path.
  assign w_sample = bus.ex_valid & ~bus.stall_in & (r_state == ST_IDLE);
  assign w_event  = w_sample & (bus.ex_jump != bus.ex_pred_taken);
  assign w_fix_pc = bus.ex_jump ? bus.ex_target : (bus.ex_pc + XLEN'(4));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_redirect_pc <= '0;
    end else if (!bus.stall_in) begin
      case (r_state)
        ST_IDLE: begin
          if (w_event) begin
            r_state       <= ST_REDIRECT;
            r_redirect_pc <= w_fix_pc;
          end
        end
        ST_REDIRECT: begin
          if (FLUSH_CYCLES > 1) begin
            r_state <= ST_DRAIN;
            r_cnt   <= DRAIN_LOAD;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_DRAIN: begin
          // Leave on the edge where the count reaches zero.
          if (r_cnt <= 3'd1) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt   <= r_cnt - 3'd1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // Outputs decode the registered state, so they appear one cycle after the
  // mispredict and freeze with it under stall.
  assign bus.pc_sel      = (r_state == ST_REDIRECT);
  assign bus.flush_id    = (r_state == ST_REDIRECT);
  assign bus.flush_if    = (r_state == ST_REDIRECT) | (r_state == ST_DRAIN);
  assign bus.busy        = (r_state != ST_IDLE);
  assign bus.redirect_pc = r_redirect_pc;

`ifdef BRANCH_REDIRECT_PERF_CNT_EN
  logic [31:0] r_branch_cnt;
  logic [31:0] r_mispred_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_branch_cnt  <= '0;
      r_mispred_cnt <= '0;
    end else begin
      if (w_sample && (r_branch_cnt != '1))
        r_branch_cnt <= r_branch_cnt + 32'd1;
      if (w_event && (r_mispred_cnt != '1))
        r_mispred_cnt <= r_mispred_cnt + 32'd1;
    end
  end

  assign bus.branch_cnt  = r_branch_cnt;
  assign bus.mispred_cnt = r_mispred_cnt;
`endif

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed self-checking bench for branch_redirect_ctrl.
//   Two instances: FLUSH_CYCLES=2 (main sequence) and FLUSH_CYCLES=1.
//   Each step drives inputs, queues the expected post-edge outputs and
//   checks them one edge later.
module tb_branch_redirect_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  branch_redirect_ctrl_if #(.XLEN(32)) b2 ();
  branch_redirect_ctrl_if #(.XLEN(32)) b1 ();

  branch_redirect_ctrl #(.FLUSH_CYCLES(2), .XLEN(32)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (b2)
  );

  branch_redirect_ctrl #(.FLUSH_CYCLES(1), .XLEN(32)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (b1)
  );

  typedef struct {
    int          d;
    string       tag;
    logic [3:0]  outs;   // {pc_sel, flush_if, flush_id, busy}
    logic        chk_rpc;
    logic [31:0] rpc;
  } exp_t;

  exp_t sb[$];
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // d selects the instance (2 or 1); the other one sees idle inputs.
  task automatic step(input int d, input string tag,
                      input logic rs, input logic st, input logic v,
                      input logic j, input logic p,
                      input logic [31:0] pc, input logic [31:0] tgt,
                      input logic [3:0] e_outs, input logic e_chk,
                      input logic [31:0] e_rpc);
    exp_t e;
    logic [3:0]  o;
    logic [31:0] r;
    @(negedge clk);
    rst = rs;
    b2.ex_valid = 1'b0; b2.ex_jump = 1'b0; b2.ex_pred_taken = 1'b0;
    b2.ex_pc = '0; b2.ex_target = '0; b2.stall_in = 1'b0;
    b1.ex_valid = 1'b0; b1.ex_jump = 1'b0; b1.ex_pred_taken = 1'b0;
    b1.ex_pc = '0; b1.ex_target = '0; b1.stall_in = 1'b0;
    if (d == 2) begin
      b2.ex_valid = v; b2.ex_jump = j; b2.ex_pred_taken = p;
      b2.ex_pc = pc; b2.ex_target = tgt; b2.stall_in = st;
    end else begin
      b1.ex_valid = v; b1.ex_jump = j; b1.ex_pred_taken = p;
      b1.ex_pc = pc; b1.ex_target = tgt; b1.stall_in = st;
    end
    sb.push_back('{d, tag, e_outs, e_chk, e_rpc});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    if (e.d == 2) begin
      o = {b2.pc_sel, b2.flush_if, b2.flush_id, b2.busy};
      r = b2.redirect_pc;
    end else begin
      o = {b1.pc_sel, b1.flush_if, b1.flush_id, b1.busy};
      r = b1.redirect_pc;
    end
    chk({e.tag, ".sel_if_id_busy"}, {28'd0, o}, {28'd0, e.outs});
    if (e.chk_rpc) chk({e.tag, ".redirect_pc"}, r, e.rpc);
  endtask

  localparam logic [3:0] O_IDLE  = 4'b0000;
  localparam logic [3:0] O_RDR   = 4'b1111;
  localparam logic [3:0] O_DRAIN = 4'b0101;

  initial begin
    rst = 1'b1;
    b2.ex_valid = 1'b0; b2.ex_jump = 1'b0; b2.ex_pred_taken = 1'b0;
    b2.ex_pc = '0; b2.ex_target = '0; b2.stall_in = 1'b0;
    b1.ex_valid = 1'b0; b1.ex_jump = 1'b0; b1.ex_pred_taken = 1'b0;
    b1.ex_pc = '0; b1.ex_target = '0; b1.stall_in = 1'b0;

    //   d  tag           rs st v  j  p  pc            target        outs     chk rpc
    step(2, "reset",      1, 1, 1, 1, 0, 32'h0,        32'h44,       O_IDLE,  1, 32'h0);
`ifdef BRANCH_REDIRECT_PERF_CNT_EN
    chk("reset.branch_cnt",  b2.branch_cnt,  32'd0);
    chk("reset.mispred_cnt", b2.mispred_cnt, 32'd0);
`endif
    step(2, "correct",    0, 0, 1, 1, 1, 32'h20,       32'h80,       O_IDLE,  1, 32'h0);
    step(2, "nt2t",       0, 0, 1, 1, 0, 32'h40,       32'h100,      O_RDR,   1, 32'h100);
    step(2, "nt2t.drain", 0, 0, 0, 0, 0, 32'h0,        32'h0,        O_DRAIN, 0, 32'h0);
    step(2, "nt2t.idle",  0, 0, 0, 0, 0, 32'h0,        32'h0,        O_IDLE,  1, 32'h100);
    step(2, "wrap",       0, 0, 1, 0, 1, 32'hFFFF_FFFC, 32'h200,     O_RDR,   1, 32'h0);
    step(2, "wrap.drain", 0, 0, 0, 0, 0, 32'h0,        32'h0,        O_DRAIN, 0, 32'h0);
    step(2, "wrap.idle",  0, 0, 0, 0, 0, 32'h0,        32'h0,        O_IDLE,  0, 32'h0);
    step(2, "stl",        0, 0, 1, 0, 1, 32'h1000,     32'h9000,     O_RDR,   1, 32'h1004);
    step(2, "stl.h1",     0, 1, 1, 1, 0, 32'h0,        32'hA000,     O_RDR,   1, 32'h1004);
    step(2, "stl.h2",     0, 1, 1, 1, 0, 32'h0,        32'hA000,     O_RDR,   1, 32'h1004);
    step(2, "stl.h3",     0, 1, 1, 1, 0, 32'h0,        32'hA000,     O_RDR,   1, 32'h1004);
    step(2, "stl.drain",  0, 0, 0, 0, 0, 32'h0,        32'h0,        O_DRAIN, 0, 32'h0);
    step(2, "stl.dhold",  0, 1, 0, 0, 0, 32'h0,        32'h0,        O_DRAIN, 0, 32'h0);
    step(2, "stl.idle",   0, 0, 0, 0, 0, 32'h0,        32'h0,        O_IDLE,  1, 32'h1004);
    step(2, "idlestall",  0, 1, 1, 1, 0, 32'h0,        32'h2000,     O_IDLE,  1, 32'h1004);
    step(2, "rst2",       1, 0, 0, 0, 0, 32'h0,        32'h0,        O_IDLE,  1, 32'h0);
    step(2, "wp",         0, 0, 1, 1, 0, 32'h0,        32'h300,      O_RDR,   1, 32'h300);
    step(2, "wp.inrdr",   0, 0, 1, 1, 0, 32'h0,        32'h400,      O_DRAIN, 0, 32'h0);
    step(2, "wp.indrain", 0, 0, 1, 1, 0, 32'h0,        32'h500,      O_IDLE,  0, 32'h0);
    step(2, "wp.after",   0, 0, 0, 0, 0, 32'h0,        32'h0,        O_IDLE,  1, 32'h300);
    step(2, "wp.correct", 0, 0, 1, 0, 0, 32'h50,       32'h600,      O_IDLE,  1, 32'h300);
`ifdef BRANCH_REDIRECT_PERF_CNT_EN
    chk("wp.branch_cnt",  b2.branch_cnt,  32'd2);
    chk("wp.mispred_cnt", b2.mispred_cnt, 32'd1);
`endif
    step(2, "rd",         0, 0, 1, 1, 0, 32'h0,        32'h600,      O_RDR,   1, 32'h600);
    step(2, "rd.drain",   0, 0, 0, 0, 0, 32'h0,        32'h0,        O_DRAIN, 0, 32'h0);
    step(2, "rd.rst",     1, 1, 1, 1, 0, 32'h0,        32'h680,      O_IDLE,  1, 32'h0);
    step(2, "rd.fresh",   0, 0, 1, 1, 0, 32'h0,        32'h700,      O_RDR,   1, 32'h700);
    step(2, "rd.fdrain",  0, 0, 0, 0, 0, 32'h0,        32'h0,        O_DRAIN, 0, 32'h0);
    step(2, "rd.fidle",   0, 0, 0, 0, 0, 32'h0,        32'h0,        O_IDLE,  0, 32'h0);
`ifdef BRANCH_REDIRECT_PERF_CNT_EN
    chk("rd.branch_cnt",  b2.branch_cnt,  32'd1);
    chk("rd.mispred_cnt", b2.mispred_cnt, 32'd1);
`endif
    step(1, "fc1.reset",  1, 0, 0, 0, 0, 32'h0,        32'h0,        O_IDLE,  1, 32'h0);
    step(1, "fc1.rdr",    0, 0, 1, 1, 0, 32'h0,        32'h800,      O_RDR,   1, 32'h800);
    step(1, "fc1.idle",   0, 0, 0, 0, 0, 32'h0,        32'h0,        O_IDLE,  1, 32'h800);
    step(1, "fc1.idle2",  0, 0, 0, 0, 0, 32'h0,        32'h0,        O_IDLE,  0, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
